// File: rtl/pipeline_hazard_unit.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock, EX redirect squash,
// multi-cycle mul front-end freeze, and a saturating stall-cycle counter.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// RUN      | normal issue; redirect > mul entry > load-use, in that priority
// MUL_WAIT | mul holds EX; front end frozen while cnt>0, release when cnt==0
module pipeline_hazard_unit #(
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             EX_R_Enable,
  input  logic [4:0]       EX_WriteReg,
  input  logic             EX_IsMul,
  input  logic             EX_Redirect,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IDEX_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             EXMEM_Bubble,
  output logic             MulBusy,
  output logic [CNT_W-1:0] StallCount
);

  typedef enum logic {RUN, MUL_WAIT} state_t;

  localparam bit         MUL_STALLS = (MUL_CYCLES > 1);
  localparam logic [3:0] CNT_INIT   = MUL_STALLS ? 4'(MUL_CYCLES - 2) : 4'd0;

  state_t     state;
  logic [3:0] cnt;
  logic       load_use;
  logic       stall;
  logic       enter_mul;

  // A load targeting $0 never produces a value worth waiting for.
  assign load_use = EX_R_Enable && (EX_WriteReg != 5'd0) &&
                    ((ID_UsesRs && (ID_Rs == EX_WriteReg)) ||
                     (ID_UsesRt && (ID_Rt == EX_WriteReg)));

  always_comb begin
    PC_Write     = 1'b1;
    IFID_Write   = 1'b1;
    IDEX_Write   = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Flush   = 1'b0;
    EXMEM_Bubble = 1'b0;
    MulBusy      = 1'b0;
    stall        = 1'b0;
    enter_mul    = 1'b0;
    if (!Reset) begin
      unique case (state)
        RUN: begin
          if (EX_Redirect) begin
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
          end else if (EX_IsMul && MUL_STALLS) begin
            PC_Write     = 1'b0;
            IFID_Write   = 1'b0;
            IDEX_Write   = 1'b0;
            EXMEM_Bubble = 1'b1;
            stall        = 1'b1;
            enter_mul    = 1'b1;
          end else if (load_use) begin
            PC_Write   = 1'b0;
            IFID_Write = 1'b0;
            IDEX_Flush = 1'b1;
            stall      = 1'b1;
          end
        end
        MUL_WAIT: begin
          MulBusy = 1'b1;
          if (cnt != 4'd0) begin
            PC_Write     = 1'b0;
            IFID_Write   = 1'b0;
            IDEX_Write   = 1'b0;
            EXMEM_Bubble = 1'b1;
            stall        = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= RUN;
      cnt        <= 4'd0;
      StallCount <= '0;
    end else begin
      if (stall && (StallCount != {CNT_W{1'b1}}))
        StallCount <= StallCount + CNT_W'(1);
      unique case (state)
        RUN: begin
          if (enter_mul) begin
            state <= MUL_WAIT;
            cnt   <= CNT_INIT;
          end
        end
        MUL_WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else             state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
